clock_counter: RTL and testbench
================================

CLOCK_COUNTER -- requirements
Module: clock_counter

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, giving clk cycles per second.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port key_mode, input, 1 bit: single-cycle pulse (already debounced) that advances the mode.
REQ-005 The block SHALL have port key_inc, input, 1 bit: single-cycle pulse (already debounced) that increments the selected field.
REQ-006 The block SHALL have ports hr_t, hr_u, min_t, min_u, sec_t, sec_u, output, 5 bits each: digit codes for the downstream hex decoders.
REQ-007 The block SHALL have port sec_tick, output, 1 bit: one-cycle pulse each elapsed second in RUN.
REQ-008 The block SHALL have port mode, output, 2 bits: current state (0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC).

Function
REQ-009 The prescaler SHALL count 0..CLK_FREQ-1 and wrap; sec_tick SHALL be 1 exactly in the cycle the prescaler equals CLK_FREQ-1 while in RUN.
REQ-010 Time SHALL be held as 24-hour BCD: hours 00-23, minutes 00-59, seconds 00-59.
REQ-011 On sec_tick, seconds SHALL increment; 59->00 SHALL carry to minutes; minutes 59->00 SHALL carry to hours; 23:59:59 SHALL wrap to 00:00:00 in one cycle.
REQ-012 The state machine SHALL advance RUN->SET_HR->SET_MIN->SET_SEC->RUN, one step per key_mode pulse.
REQ-013 In SET_* states, the prescaler SHALL hold at 0 and time SHALL not advance.
REQ-014 On leaving SET_SEC for RUN, the prescaler SHALL start from 0, so the first sec_tick occurs CLK_FREQ cycles later.
REQ-015 In SET_HR, SET_MIN, or SET_SEC, key_inc SHALL increment only the selected field modulo 24/60/60 with no carry.
REQ-016 key_inc in RUN SHALL be ignored.
REQ-017 If key_mode and key_inc are both high in one cycle, key_mode SHALL take effect and key_inc SHALL be ignored.
REQ-018 If key_mode arrives in RUN in the same cycle as sec_tick, the time increment SHALL still be applied, then the state SHALL move to SET_HR.
REQ-019 A blink flag SHALL toggle every CLK_FREQ/2 cycles, running in all states.
REQ-020 In a SET_* state with blink=1, both digits of the selected field SHALL output 5'h10 (blank code); all other digits SHALL output {1'b0, BCD digit}.
REQ-021 Digit outputs SHALL be a direct function of registered state, with no added latency: a time change is visible the cycle after the triggering edge.

Reset
REQ-022 While reset=1 at a clk edge, time SHALL become 00:00:00, the prescaler 0, blink 0, and the state RUN; sec_tick SHALL be 0 and all digit outputs 5'h00.
REQ-023 Reset SHALL override key_mode, key_inc, and tick in the same cycle, including mid-SET operation.

Structure
REQ-024 Package clock_pkg SHALL hold the state enum, the 5-bit digit type, DIGIT_BLANK = 5'h10, and moduli HR_MOD=24 and MS_MOD=60.
REQ-025 Sub-module bcd_mod_counter SHALL be instanced three times (sec, min, hr).
REQ-026 bcd_mod_counter SHALL be a parameterised two-digit BCD counter with inputs clk, reset, and inc, a modulus parameter, and outputs tens, units, and wrap.

Verification (CLK_FREQ=4)
REQ-027 Release reset and run 12 cycles -> exactly 3 sec_tick pulses, 4 cycles apart; display 00:00:03.
REQ-028 Preload 23:59:59 via SET mode, return to RUN, wait one tick -> display 00:00:00 on the single following cycle.
REQ-029 Send key_mode, then 25 key_inc pulses -> mode=1, hours=01, minutes and seconds unchanged.
REQ-030 In SET_MIN with blink=1 -> min_t=min_u=5'h10 and hr/sec digits show values; with blink=0 -> all digits show values.
REQ-031 Assert key_mode and key_inc in the same cycle in SET_HR -> mode=2, hours unchanged.
REQ-032 Assert reset during SET_SEC at 12:34:56 -> next cycle mode=0, all digits 5'h00, sec_tick=0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the 24-hour BCD clock: mode states, digit codes
// and field moduli, plus small helpers used by the datapath.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SET_HR  = 2'd1,
      ST_SET_MIN = 2'd2,
      ST_SET_SEC = 2'd3
   } state_e;

   typedef logic [4:0] digit_t;

   localparam digit_t DIGIT_BLANK = 5'h10;
   localparam int     HR_MOD      = 24;
   localparam int     MS_MOD      = 60;

   function automatic digit_t to_digit(input logic [3:0] bcd, input logic blank);
      digit_t d;
      if (blank) begin
         d = DIGIT_BLANK;
      end else begin
         d = {1'b0, bcd};
      end
      return d;
   endfunction

   function automatic state_e next_state(input state_e s);
      state_e n;
      case (s)
         ST_RUN:     n = ST_SET_HR;
         ST_SET_HR:  n = ST_SET_MIN;
         ST_SET_MIN: n = ST_SET_SEC;
         ST_SET_SEC: n = ST_RUN;
         default:    n = ST_RUN;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MOD; wrap pulses in the cycle an increment
// takes the count from MOD-1 back to 00.
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter int MOD = MS_MOD
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   output logic [3:0] tens,
   output logic [3:0] units,
   output logic       wrap
);

   localparam logic [3:0] MAX_T = 4'((MOD - 1) / 10);
   localparam logic [3:0] MAX_U = 4'((MOD - 1) % 10);

   logic [3:0] tens_q, tens_d;
   logic [3:0] units_q, units_d;
   logic       at_max;

   always_comb begin
      at_max  = (tens_q == MAX_T) && (units_q == MAX_U);
      tens_d  = tens_q;
      units_d = units_q;
      if (inc) begin
         if (at_max) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
         end else if (units_q == 4'd9) begin
            tens_d  = tens_q + 4'd1;
            units_d = 4'd0;
         end else begin
            units_d = units_q + 4'd1;
         end
      end else begin
         tens_d  = tens_q;
         units_d = units_q;
      end
      wrap = inc && at_max;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tens_q  <= 4'd0;
         units_q <= 4'd0;
      end else begin
         tens_q  <= tens_d;
         units_q <= units_d;
      end
   end

   assign tens  = tens_q;
   assign units = units_q;

endmodule

// File: rtl/clock_counter.sv
// 24-hour BCD clock with a seconds prescaler, a four-state set mode driven by
// debounced key pulses, and blinking of the field being edited.
module clock_counter
   import clock_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_mode,
   input  logic       key_inc,
   output logic [4:0] hr_t,
   output logic [4:0] hr_u,
   output logic [4:0] min_t,
   output logic [4:0] min_u,
   output logic [4:0] sec_t,
   output logic [4:0] sec_u,
   output logic       sec_tick,
   output logic [1:0] mode
);

   localparam int HALF = (CLK_FREQ / 2 > 0) ? CLK_FREQ / 2 : 1;
   localparam int PW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

   state_e          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
   logic            blink_q, blink_d;
   logic            tick, set_inc;
   logic            inc_sec, inc_min, inc_hr;
   logic            wrap_sec, wrap_min, hr_wrap_unused;
   logic [3:0]      sec_tens, sec_units, min_tens, min_units, hr_tens, hr_units;

   always_comb begin
      tick    = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
      set_inc = key_inc && !key_mode;
      state_d = key_mode ? next_state(state_q) : state_q;
      // Held at zero outside RUN so the first second after setting is a full one.
      if ((state_q != ST_RUN) || (state_d != ST_RUN) || tick) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + PW'(1);
      end
      if (blink_cnt_q == BLINK_MAX) begin
         blink_cnt_d = '0;
         blink_d     = !blink_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BW'(1);
         blink_d     = blink_q;
      end
   end

   assign inc_sec = tick || ((state_q == ST_SET_SEC) && set_inc);
   assign inc_min = (tick && wrap_sec) || ((state_q == ST_SET_MIN) && set_inc);
   assign inc_hr  = (tick && wrap_min) || ((state_q == ST_SET_HR) && set_inc);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         presc_q     <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
      end
   end

   bcd_mod_counter #(.MOD(MS_MOD)) u_sec (
      .clk(clk), .reset(reset), .inc(inc_sec),
      .tens(sec_tens), .units(sec_units), .wrap(wrap_sec)
   );

   bcd_mod_counter #(.MOD(MS_MOD)) u_min (
      .clk(clk), .reset(reset), .inc(inc_min),
      .tens(min_tens), .units(min_units), .wrap(wrap_min)
   );

   bcd_mod_counter #(.MOD(HR_MOD)) u_hr (
      .clk(clk), .reset(reset), .inc(inc_hr),
      .tens(hr_tens), .units(hr_units), .wrap(hr_wrap_unused)
   );

   assign hr_t     = to_digit(hr_tens,   blink_q && (state_q == ST_SET_HR));
   assign hr_u     = to_digit(hr_units,  blink_q && (state_q == ST_SET_HR));
   assign min_t    = to_digit(min_tens,  blink_q && (state_q == ST_SET_MIN));
   assign min_u    = to_digit(min_units, blink_q && (state_q == ST_SET_MIN));
   assign sec_t    = to_digit(sec_tens,  blink_q && (state_q == ST_SET_SEC));
   assign sec_u    = to_digit(sec_units, blink_q && (state_q == ST_SET_SEC));
   assign sec_tick = tick;
   assign mode     = state_q;

endmodule

// File: tb/tb_clock_counter.sv
// Directed bench for clock_counter at CLK_FREQ=4: reset, ticking, day wrap,
// set-mode increments, blinking, key priority and reset during set.
module tb_clock_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       key_mode = 1'b0;
   logic       key_inc = 1'b0;
   logic [4:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u;
   logic       sec_tick;
   logic [1:0] mode;
   logic [29:0] disp;
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;

   clock_counter #(.CLK_FREQ(4)) dut (
      .clk(clk), .reset(reset), .key_mode(key_mode), .key_inc(key_inc),
      .hr_t(hr_t), .hr_u(hr_u), .min_t(min_t), .min_u(min_u),
      .sec_t(sec_t), .sec_u(sec_u), .sec_tick(sec_tick), .mode(mode)
   );

   always #5 clk = ~clk;
   assign disp = {hr_t, hr_u, min_t, min_u, sec_t, sec_u};

   // cycles since reset released; blink is high in the second half of every 4
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   function automatic bit blink_now();
      return ((cyc / 2) % 2) == 1;
   endfunction

   function automatic logic [9:0] dig(input int v, input bit blank);
      logic [3:0] t, u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      if (blank) return {5'h10, 5'h10};
      return {1'b0, t, 1'b0, u};
   endfunction

   function automatic logic [29:0] exp_time(input int h, input int m, input int s,
                                            input int sel, input bit blink);
      return {dig(h, blink && sel == 1), dig(m, blink && sel == 2), dig(s, blink && sel == 3)};
   endfunction

   task automatic do_reset();
      reset = 1'b1; key_mode = 1'b0; key_inc = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse_mode();
      key_mode = 1'b1;
      @(negedge clk);
      key_mode = 1'b0;
   endtask

   task automatic inc_n(input int n);
      if (n > 0) begin
         key_inc = 1'b1;
         repeat (n) @(negedge clk);
         key_inc = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", mode); end
      total++; if (disp !== 30'h0) begin bad++; $display("FAIL reset_disp got=%h exp=0", disp); end
      total++; if (sec_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", sec_tick); end
   endtask

   task automatic test_run_ticks();
      int nt = 0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         total++;
         if (sec_tick !== ((i % 4) == 3)) begin
            bad++; $display("FAIL run_tick_%0d got=%b exp=%b", i, sec_tick, (i % 4) == 3);
         end
         if (sec_tick === 1'b1) nt++;
         @(negedge clk);
      end
      total++; if (nt != 3) begin bad++; $display("FAIL run_tick_count got=%0d exp=3", nt); end
      total++; if (disp !== exp_time(0, 0, 3, 0, 1'b0)) begin
         bad++; $display("FAIL run_disp got=%h exp=%h", disp, exp_time(0, 0, 3, 0, 1'b0));
      end
   endtask

   task automatic test_day_wrap();
      do_reset();
      pulse_mode(); inc_n(23);
      pulse_mode(); inc_n(59);
      pulse_mode(); inc_n(59);
      total++; if (mode !== 2'd3 || disp !== exp_time(23, 59, 59, 3, blink_now())) begin
         bad++; $display("FAIL preload got=%0d/%h exp=3/%h", mode, disp, exp_time(23, 59, 59, 3, blink_now()));
      end
      pulse_mode();
      for (int i = 0; i < 3; i++) begin
         total++; if (sec_tick !== 1'b0) begin bad++; $display("FAIL early_tick_%0d got=%b exp=0", i, sec_tick); end
         @(negedge clk);
      end
      total++; if (sec_tick !== 1'b1 || disp !== exp_time(23, 59, 59, 0, 1'b0)) begin
         bad++; $display("FAIL pre_wrap got=%b/%h exp=1/%h", sec_tick, disp, exp_time(23, 59, 59, 0, 1'b0));
      end
      @(negedge clk);
      total++; if (disp !== 30'h0 || sec_tick !== 1'b0) begin
         bad++; $display("FAIL day_wrap got=%b/%h exp=0/0", sec_tick, disp);
      end
   endtask

   task automatic test_hour_inc();
      do_reset();
      pulse_mode(); inc_n(25);
      total++; if (mode !== 2'd1) begin bad++; $display("FAIL hr_mode got=%0d exp=1", mode); end
      total++; if (disp !== exp_time(1, 0, 0, 1, blink_now())) begin
         bad++; $display("FAIL hr_inc got=%h exp=%h", disp, exp_time(1, 0, 0, 1, blink_now()));
      end
   endtask

   task automatic test_same_cycle();
      key_mode = 1'b1; key_inc = 1'b1;
      @(negedge clk);
      key_mode = 1'b0; key_inc = 1'b0;
      total++; if (mode !== 2'd2) begin bad++; $display("FAIL both_mode got=%0d exp=2", mode); end
      total++; if (disp !== exp_time(1, 0, 0, 2, blink_now())) begin
         bad++; $display("FAIL both_hr got=%h exp=%h", disp, exp_time(1, 0, 0, 2, blink_now()));
      end
   endtask

   task automatic test_blink();
      int nblank = 0;
      inc_n(7);
      for (int i = 0; i < 4; i++) begin
         total++; if (disp !== exp_time(1, 7, 0, 2, blink_now())) begin
            bad++; $display("FAIL blink_%0d got=%h exp=%h", i, disp, exp_time(1, 7, 0, 2, blink_now()));
         end
         if (min_t === 5'h10) nblank++;
         @(negedge clk);
      end
      total++; if (nblank != 2) begin bad++; $display("FAIL blink_count got=%0d exp=2", nblank); end
   endtask

   task automatic test_no_carry();
      inc_n(53);
      total++; if (disp !== exp_time(1, 0, 0, 2, blink_now())) begin
         bad++; $display("FAIL min_nocarry got=%h exp=%h", disp, exp_time(1, 0, 0, 2, blink_now()));
      end
      pulse_mode(); inc_n(60);
      total++; if (mode !== 2'd3 || disp !== exp_time(1, 0, 0, 3, blink_now())) begin
         bad++; $display("FAIL sec_nocarry got=%0d/%h exp=3/%h", mode, disp, exp_time(1, 0, 0, 3, blink_now()));
      end
   endtask

   task automatic test_reset_mid_set();
      do_reset();
      pulse_mode(); inc_n(12);
      pulse_mode(); inc_n(34);
      pulse_mode(); inc_n(56);
      total++; if (mode !== 2'd3 || disp !== exp_time(12, 34, 56, 3, blink_now())) begin
         bad++; $display("FAIL set_123456 got=%0d/%h exp=3/%h", mode, disp, exp_time(12, 34, 56, 3, blink_now()));
      end
      reset = 1'b1; key_inc = 1'b1; key_mode = 1'b1;
      @(negedge clk);
      reset = 1'b0; key_inc = 1'b0; key_mode = 1'b0;
      total++; if (mode !== 2'd0 || disp !== 30'h0 || sec_tick !== 1'b0) begin
         bad++; $display("FAIL mid_reset got=%0d/%h/%b exp=0/0/0", mode, disp, sec_tick);
      end
   endtask

   task automatic test_mode_on_tick();
      do_reset();
      repeat (3) @(negedge clk);
      total++; if (sec_tick !== 1'b1) begin bad++; $display("FAIL tick_before_mode got=%b exp=1", sec_tick); end
      pulse_mode();
      total++; if (mode !== 2'd1 || disp !== exp_time(0, 0, 1, 1, blink_now())) begin
         bad++; $display("FAIL mode_on_tick got=%0d/%h exp=1/%h", mode, disp, exp_time(0, 0, 1, 1, blink_now()));
      end
      for (int i = 0; i < 8; i++) begin
         total++; if (sec_tick !== 1'b0) begin bad++; $display("FAIL set_hold_tick_%0d got=%b exp=0", i, sec_tick); end
         @(negedge clk);
      end
      total++; if (disp !== exp_time(0, 0, 1, 1, blink_now())) begin
         bad++; $display("FAIL set_hold got=%h exp=%h", disp, exp_time(0, 0, 1, 1, blink_now()));
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_run_ticks();
      test_day_wrap();
      test_hour_inc();
      test_same_cycle();
      test_blink();
      test_no_carry();
      test_reset_mid_set();
      test_mode_on_tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
